uart_lap_frame_tx: RTL and testbench

//  Queued, framed lap-time transmitter. It sits between the stopwatch core
//  (cronometro) and the byte-level uart_tx engine.
//  - Captures {min,seg,cent} on each lap/stop pulse into a DEPTH-entry FIFO.
//  - Sends each entry as a framed record, in binary or ASCII form.
//  - Uses a full start/busy handshake with the engine, so records are never

---
 rtl/uart_lap_frame_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_lap_frame_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lap_frame_tx.sv
// uart_lap_frame_tx
//   Queued, framed lap-time transmitter between the stopwatch core and a
//   byte-level uart_tx engine. Each lap/stop pulse captures {lap_id,min,seg,cent}
//   into a small FIFO. Entries are drained one at a time and sent as a framed
//   record, either binary (HEADER, id, min, seg, cent[, xor csum]) or ASCII
//   ("MM:SS.CC\r\n"). A start/busy handshake paces every byte.
// Ports
//   clk, reset_n          clock, async active-low reset
//   i_capture             1-cycle pulse: enqueue current time
//   i_clear               flush FIFO, clear overflow and lap counter
//   i_min/i_seg/i_cent    current stopwatch time
//   o_tx_start/o_tx_byte  1-cycle start pulse and byte to uart_tx
//   i_tx_busy             uart_tx busy flag
//   o_fifo_count          queued records
//   o_overflow            sticky: a capture was dropped
//   o_frame_active        a frame is being sent
//   o_lap_id              id of the next record to be accepted
module uart_lap_frame_tx #(
  parameter int         MIN_W      = 4,
  parameter int         SEG_W      = 6,
  parameter int         CENT_W     = 7,
  parameter int         DEPTH      = 4,
  parameter int         ASCII_MODE = 0,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         USE_CSUM   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_capture,
  input  logic                     i_clear,
  input  logic [MIN_W-1:0]         i_min,
  input  logic [SEG_W-1:0]         i_seg,
  input  logic [CENT_W-1:0]        i_cent,
  output logic                     o_tx_start,
  output logic [7:0]               o_tx_byte,
  input  logic                     i_tx_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_overflow,
  output logic                     o_frame_active,
  output logic [7:0]               o_lap_id
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = 8 + MIN_W + SEG_W + CENT_W;
  localparam int NB    = (ASCII_MODE != 0) ? 10 : ((USE_CSUM != 0) ? 6 : 5);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

  // ---------------- capture FIFO ----------------
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [7:0]       lap_q;
  logic             ovf_q;
  logic             full, empty, push, pop, drop;
  logic [ENT_W-1:0] head;

  state_t state_q, state_d;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = (state_q == S_LOAD) && !empty;
  // A pop in the same cycle frees a slot, so a capture into a full FIFO is kept.
  assign push  = i_capture && !i_clear && (!full || pop);
  assign drop  = i_capture && !i_clear && full && !pop;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {lap_q, i_min, i_seg, i_cent};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      lap_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      lap_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        lap_q    <= lap_q + 8'd1;
      end
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (drop) ovf_q <= 1'b1;
    end
  end

  // ---------------- frame latch ----------------
  // Loaded on the pop, so a clear arriving later cannot disturb the frame.
  logic [7:0]        f_lap_q;
  logic [MIN_W-1:0]  f_min_q;
  logic [SEG_W-1:0]  f_seg_q;
  logic [CENT_W-1:0] f_cent_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_lap_q  <= '0;
      f_min_q  <= '0;
      f_seg_q  <= '0;
      f_cent_q <= '0;
    end else if (pop) begin
      {f_lap_q, f_min_q, f_seg_q, f_cent_q} <= head;
    end
  end

  // ---------------- byte selection ----------------
  function automatic logic [7:0] sat99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  // Tens digit by comparing against 10..90; avoids a divider.
  function automatic logic [3:0] tens_of(input logic [7:0] v);
    logic [3:0] t;
    t = 4'd0;
    for (int i = 1; i < 10; i++) if (v >= 8'(i * 10)) t = 4'(i);
    return t;
  endfunction

  function automatic logic [7:0] asc_tens(input logic [7:0] v);
    return 8'h30 + {4'd0, tens_of(sat99(v))};
  endfunction

  function automatic logic [7:0] asc_units(input logic [7:0] v);
    logic [7:0] s;
    s = sat99(v);
    return 8'h30 + (s - {4'd0, tens_of(s)} * 8'd10);
  endfunction

  logic [3:0] idx_q, idx_d;
  logic [7:0] cur_byte, csum;

  assign csum = f_lap_q ^ 8'(f_min_q) ^ 8'(f_seg_q) ^ 8'(f_cent_q);

  always_comb begin
    cur_byte = 8'h00;
    if (ASCII_MODE != 0) begin
      case (idx_q)
        4'd0:    cur_byte = asc_tens(8'(f_min_q));
        4'd1:    cur_byte = asc_units(8'(f_min_q));
        4'd2:    cur_byte = 8'h3A;
        4'd3:    cur_byte = asc_tens(8'(f_seg_q));
        4'd4:    cur_byte = asc_units(8'(f_seg_q));
        4'd5:    cur_byte = 8'h2E;
        4'd6:    cur_byte = asc_tens(8'(f_cent_q));
        4'd7:    cur_byte = asc_units(8'(f_cent_q));
        4'd8:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
    end else begin
      case (idx_q)
        4'd0:    cur_byte = HEADER;
        4'd1:    cur_byte = f_lap_q;
        4'd2:    cur_byte = 8'(f_min_q);
        4'd3:    cur_byte = 8'(f_seg_q);
        4'd4:    cur_byte = 8'(f_cent_q);
        default: cur_byte = csum;
      endcase
    end
  end

  // ---------------- sender FSM ----------------
  logic       start_q, start_d;
  logic [7:0] byte_q, byte_d;
  logic       act_q, act_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      start_q <= 1'b0;
      byte_q  <= '0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      byte_q  <= byte_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    byte_d  = byte_q;
    act_d   = act_q;
    case (state_q)
      S_IDLE: if (!empty) state_d = S_LOAD;
      S_LOAD: begin
        // FIFO may have been cleared since S_IDLE saw it non-empty.
        if (!empty) begin
          idx_d   = '0;
          act_d   = 1'b1;
          state_d = S_SEND;
        end else begin
          act_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (!i_tx_busy) begin
          start_d = 1'b1;
          byte_d  = cur_byte;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (i_tx_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!i_tx_busy) begin
          if (idx_q != 4'(NB - 1)) begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SEND;
          end else if (!empty) begin
            state_d = S_LOAD;  // back-to-back frame, no idle gap
          end else begin
            act_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_tx_start     = start_q;
  assign o_tx_byte      = byte_q;
  assign o_fifo_count   = cnt_q;
  assign o_overflow     = ovf_q;
  assign o_frame_active = act_q;
  assign o_lap_id       = lap_q;

endmodule

// File: tb/tb_uart_lap_frame_tx.sv
// Bench for uart_lap_frame_tx: a binary/csum instance (0) and an ASCII instance (1),
// each with a simple uart_tx engine model. Expected bytes go into per-instance
// queues when captures are issued; the monitor pops them on every o_tx_start.
module tb_uart_lap_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: binary with checksum
  logic cap0, clr0, st0, bsy0, ovf0, act0;
  logic [3:0] min0; logic [5:0] seg0; logic [6:0] cent0;
  logic [7:0] by0, lap0; logic [2:0] cnt0;
  // instance 1: ASCII
  logic cap1, clr1, st1, bsy1, ovf1, act1;
  logic [3:0] min1; logic [5:0] seg1; logic [6:0] cent1;
  logic [7:0] by1, lap1; logic [2:0] cnt1;

  uart_lap_frame_tx #(.ASCII_MODE(0), .USE_CSUM(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_capture(cap0), .i_clear(clr0),
    .i_min(min0), .i_seg(seg0), .i_cent(cent0), .o_tx_start(st0), .o_tx_byte(by0),
    .i_tx_busy(bsy0), .o_fifo_count(cnt0), .o_overflow(ovf0),
    .o_frame_active(act0), .o_lap_id(lap0));

  uart_lap_frame_tx #(.ASCII_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_capture(cap1), .i_clear(clr1),
    .i_min(min1), .i_seg(seg1), .i_cent(cent1), .o_tx_start(st1), .o_tx_byte(by1),
    .i_tx_busy(bsy1), .o_fifo_count(cnt1), .o_overflow(ovf1),
    .o_frame_active(act1), .o_lap_id(lap1));

  // engine model state
  logic busy_r [2];
  int   dcnt [2];
  int   hcnt [2];
  int   eng_dly  = 1;
  int   eng_hold = 4;
  logic force_b  = 1'b0;
  assign bsy0 = busy_r[0] | force_b;
  assign bsy1 = busy_r[1];

  logic [7:0] eq0 [$];
  logic [7:0] eq1 [$];
  int nst0 = 0, nst1 = 0, st_cyc0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor + engine model
  logic       m_s, m_b;
  logic [7:0] m_d, m_e;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        busy_r[k] = 1'b0; dcnt[k] = 0; hcnt[k] = 0;
      end else begin
        m_s = (k == 0) ? st0 : st1;
        m_b = (k == 0) ? bsy0 : bsy1;
        m_d = (k == 0) ? by0 : by1;
        if (hcnt[k] > 0) begin hcnt[k]--; if (hcnt[k] == 0) busy_r[k] = 1'b0; end
        if (dcnt[k] > 0) begin
          dcnt[k]--;
          if (dcnt[k] == 0) begin busy_r[k] = 1'b1; hcnt[k] = eng_hold; end
        end
        if (m_s) begin
          chk($sformatf("start_while_busy%0d", k), {31'd0, m_b}, 32'd0);
          if (k == 0) begin nst0++; st_cyc0 = cyc; end else nst1++;
          if ((k == 0 ? eq0.size() : eq1.size()) == 0) begin
            chk($sformatf("unexpected_start%0d", k), {24'd0, m_d}, 32'hFFFF_FFFF);
          end else begin
            m_e = (k == 0) ? eq0.pop_front() : eq1.pop_front();
            chk($sformatf("tx_byte%0d", k), {24'd0, m_d}, {24'd0, m_e});
          end
          dcnt[k] = eng_dly;
        end
      end
    end
  end

  task automatic cap_b(input logic [3:0] m, input logic [5:0] s, input logic [6:0] c);
    min0 = m; seg0 = s; cent0 = c; cap0 = 1'b1;
    @(negedge clk); cap0 = 1'b0;
  endtask

  task automatic cap_a(input logic [3:0] m, input logic [5:0] s, input logic [6:0] c);
    min1 = m; seg1 = s; cent1 = c; cap1 = 1'b1;
    @(negedge clk); cap1 = 1'b0;
  endtask

  task automatic exp_b(input logic [7:0] id, input logic [7:0] m, input logic [7:0] s,
                       input logic [7:0] c, input logic [7:0] cs);
    eq0.push_back(8'hA5); eq0.push_back(id); eq0.push_back(m);
    eq0.push_back(s); eq0.push_back(c); eq0.push_back(cs);
  endtask

  task automatic exp_a(input logic [79:0] str);
    for (int i = 9; i >= 0; i--) eq1.push_back(str[i*8 +: 8]);
  endtask

  task automatic wait_starts0(input int n);
    for (int i = 0; i < 3000 && nst0 < n; i++) @(negedge clk);
    chk("start_timeout", {31'd0, nst0 >= n}, 32'd1);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      done = (eq0.size() == 0) && (eq1.size() == 0) && !act0 && !act1 && !bsy0 && !bsy1;
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  // per-row: min, seg, cent, csum for lap ids 0..3
  logic [7:0] tab [4][4] = '{'{8'd0, 8'd1, 8'd2, 8'h03}, '{8'd1, 8'd2, 8'd3, 8'h01},
                             '{8'd2, 8'd3, 8'd4, 8'h07}, '{8'd3, 8'd4, 8'd5, 8'h01}};

  initial begin
    int base, c0;
    reset_n = 1'b0;
    cap0 = 0; clr0 = 0; min0 = 0; seg0 = 0; cent0 = 0;
    cap1 = 0; clr1 = 0; min1 = 0; seg1 = 0; cent1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_start0", {31'd0, st0}, 0);
    chk("rst_byte0", {24'd0, by0}, 0);
    chk("rst_count0", {29'd0, cnt0}, 0);
    chk("rst_ovf0", {31'd0, ovf0}, 0);
    chk("rst_active0", {31'd0, act0}, 0);
    chk("rst_lap0", {24'd0, lap0}, 0);
    chk("rst_start1", {31'd0, st1}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // ASCII frames, including saturation of cent=120
    exp_a("01:05.99\r\n"); cap_a(4'd1, 6'd5, 7'd99);
    exp_a("00:00.99\r\n"); cap_a(4'd0, 6'd0, 7'd120);
    exp_a("09:59.50\r\n"); cap_a(4'd9, 6'd59, 7'd50);
    chk("ascii_lap_id", {24'd0, lap1}, 3);
    wait_drain();

    // binary frame and first-byte latency
    exp_b(8'h00, 8'h02, 8'h23, 8'h07, 8'h26);
    base = nst0; c0 = cyc;
    cap_b(4'd2, 6'd35, 7'd7);
    wait_starts0(base + 1);
    chk("latency", st_cyc0, c0 + 4);
    wait_drain();
    chk("active_after_frame", {31'd0, act0}, 0);
    chk("lap_after_frame", {24'd0, lap0}, 1);

    // slow engine: busy 3 cycles late, held 20
    eng_dly = 3; eng_hold = 20;
    exp_b(8'h01, 8'h0A, 8'h3B, 8'h63, 8'h53);
    cap_b(4'd10, 6'd59, 7'd99);
    wait_drain();
    eng_dly = 1; eng_hold = 4;

    // hold the engine busy on a frame's last byte, clear, then 6 captures
    exp_b(8'h02, 8'h01, 8'h01, 8'h01, 8'h03);
    base = nst0;
    cap_b(4'd1, 6'd1, 7'd1);
    wait_starts0(base + 6);
    force_b = 1'b1;
    clr0 = 1'b1; @(negedge clk); clr0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) exp_b(8'(k), tab[k][0], tab[k][1], tab[k][2], tab[k][3]);
      cap_b(4'(k), 6'(k + 1), 7'(k + 2));
    end
    chk("full_count", {29'd0, cnt0}, 4);
    chk("full_overflow", {31'd0, ovf0}, 1);
    chk("full_lap_id", {24'd0, lap0}, 4);
    repeat (30) @(negedge clk);
    force_b = 1'b0;
    wait_drain();

    // fill without overflow, then capture in the pop cycle
    exp_b(8'h04, 8'h04, 8'h04, 8'h04, 8'h00);
    base = nst0;
    cap_b(4'd4, 6'd4, 7'd4);
    wait_starts0(base + 6);
    force_b = 1'b1;
    clr0 = 1'b1; @(negedge clk); clr0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_b(8'(k), tab[k][0], tab[k][1], tab[k][2], tab[k][3]);
      cap_b(4'(k), 6'(k + 1), 7'(k + 2));
    end
    chk("refill_count", {29'd0, cnt0}, 4);
    chk("refill_overflow", {31'd0, ovf0}, 0);
    repeat (30) @(negedge clk);
    force_b = 1'b0;
    @(negedge clk);                     // FSM now in S_LOAD
    exp_b(8'h04, 8'h09, 8'h09, 8'h09, 8'h0D);
    cap_b(4'd9, 6'd9, 7'd9);            // lands with the pop
    chk("pushpop_count", {29'd0, cnt0}, 4);
    chk("pushpop_overflow", {31'd0, ovf0}, 0);
    chk("pushpop_lap_id", {24'd0, lap0}, 5);
    wait_drain();

    // clear has priority over capture
    clr0 = 1'b1; min0 = 4'd7; cap0 = 1'b1;
    @(negedge clk); clr0 = 1'b0; cap0 = 1'b0;
    chk("clear_count", {29'd0, cnt0}, 0);
    chk("clear_lap_id", {24'd0, lap0}, 0);
    repeat (10) @(negedge clk);

    // reset during byte 3 with another record queued
    exp_b(8'h00, 8'h03, 8'h03, 8'h03, 8'h03);
    base = nst0;
    cap_b(4'd3, 6'd3, 7'd3);
    cap_b(4'd5, 6'd5, 7'd5);
    wait_starts0(base + 3);
    reset_n = 1'b0;
    #1;
    chk("midrst_start", {31'd0, st0}, 0);
    chk("midrst_count", {29'd0, cnt0}, 0);
    chk("midrst_active", {31'd0, act0}, 0);
    chk("midrst_lap_id", {24'd0, lap0}, 0);
    eq0.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_b(8'h00, 8'h06, 8'h07, 8'h08, 8'h09);
    cap_b(4'd6, 6'd7, 7'd8);
    wait_drain();
    chk("final_queue0", eq0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
